// File: rtl/maxnet_pkg.sv
// Shared constants and FSM state type for the MaxNet winner-take-all controller.
package maxnet_pkg;

  localparam int MN_N         = 4;
  localparam int MN_DATA_W    = 32;
  localparam int MN_EPS_SHIFT = 3;
  localparam int MN_MAX_ITER  = 15;
  localparam int MN_ITER_W    = 4;
  localparam int MN_ADDR_W    = $clog2(MN_N);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CALC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/maxnet_controller_if.sv
// Memory port between the MaxNet controller (master) and the activation memory (slave).
interface maxnet_controller_if #(
  parameter int AW = maxnet_pkg::MN_ADDR_W,
  parameter int DW = maxnet_pkg::MN_DATA_W
);
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/maxnet_update.sv
// One lateral-inhibition step: every activation is reduced by eps times the sum
// of all the others, clamped at zero; also counts the surviving non-zero values.
module maxnet_update
  import maxnet_pkg::*;
#(
  parameter int N         = MN_N,
  parameter int DATA_W    = MN_DATA_W,
  parameter int EPS_SHIFT = MN_EPS_SHIFT
) (
  input  logic [DATA_W-1:0]    x_i [N],
  output logic [DATA_W-1:0]    x_o [N],
  output logic [$clog2(N):0]   nz_o
);
  localparam int AW = $clog2(N);
  localparam int SW = DATA_W + AW;
  localparam logic [AW:0] NZ_ONE = (AW+1)'(1);

  logic [SW-1:0] xe_s  [N];
  logic [SW-1:0] inh_s [N];
  logic [SW-1:0] sum_s;

  // Zero-extend the activations and form their total (cannot overflow SW bits).
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < N; i++) begin
      xe_s[i] = SW'(x_i[i]);
      sum_s   = sum_s + xe_s[i];
    end
  end

  // Inhibition from the other neurons, clamped subtraction and non-zero count.
  always_comb begin
    nz_o = '0;
    for (int i = 0; i < N; i++) begin
      inh_s[i] = (sum_s - xe_s[i]) >> EPS_SHIFT;
      x_o[i]   = '0;
      if (xe_s[i] > inh_s[i]) begin
        x_o[i] = x_i[i] - inh_s[i][DATA_W-1:0];
      end else begin
        x_o[i] = '0;
      end
      if (x_o[i] != '0) begin
        nz_o = nz_o + NZ_ONE;
      end else begin
        nz_o = nz_o;
      end
    end
  end
endmodule

// File: rtl/maxnet_controller.sv
// MaxNet controller: loads N activations, iterates inhibition until one survives
// or the iteration limit is hit, writes the result back and reports the winner.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int N         = MN_N,
  parameter int DATA_W    = MN_DATA_W,
  parameter int EPS_SHIFT = MN_EPS_SHIFT,
  parameter int MAX_ITER  = MN_MAX_ITER,
  parameter int ITER_W    = MN_ITER_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  maxnet_controller_if.master   mem,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [$clog2(N)-1:0]  winner_o,
  output logic                  winner_valid_o,
  output logic                  tie_o,
  output logic [ITER_W-1:0]     iter_count_o
);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0]     ADDR_LAST = AW'(N - 1);
  localparam logic [AW-1:0]     ADDR_ONE  = AW'(1);
  localparam logic [AW:0]       NZ_ONE    = (AW+1)'(1);
  localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
  localparam logic [ITER_W-1:0] ITER_LIM  = ITER_W'(MAX_ITER);

  state_t              state_q;
  logic [AW-1:0]       addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                busy_q;
  logic                done_q;
  logic [AW-1:0]       winner_q;
  logic                valid_q;
  logic                tie_q;
  logic [ITER_W-1:0]   iter_q;
  logic [DATA_W-1:0]   x_q [N];
  logic [DATA_W-1:0]   x_d [N];
  logic [AW:0]         nz_d;
  logic [AW-1:0]       win_s;
  logic [DATA_W-1:0]   best_s;
  logic [AW:0]         nz_s;

  maxnet_update #(.N(N), .DATA_W(DATA_W), .EPS_SHIFT(EPS_SHIFT)) u_update (
    .x_i  (x_q),
    .x_o  (x_d),
    .nz_o (nz_d)
  );

  // Final-result summary: strict '>' keeps the lowest index among equal maxima.
  always_comb begin
    win_s  = '0;
    best_s = x_q[0];
    nz_s   = '0;
    for (int i = 0; i < N; i++) begin
      if (x_q[i] > best_s) begin
        best_s = x_q[i];
        win_s  = AW'(i);
      end else begin
        best_s = best_s;
      end
      if (x_q[i] != '0) begin
        nz_s = nz_s + NZ_ONE;
      end else begin
        nz_s = nz_s;
      end
    end
  end

  // Control FSM with all outputs registered; addr_q doubles as the word index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      winner_q <= '0;
      valid_q  <= 1'b0;
      tie_q    <= 1'b0;
      iter_q   <= '0;
      for (int i = 0; i < N; i++) x_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= ST_LOAD;
            addr_q  <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          // Negative activations enter the competition as zero.
          x_q[addr_q] <= mem.mem_rdata[DATA_W-1] ? '0 : mem.mem_rdata;
          if (addr_q == ADDR_LAST) begin
            state_q <= ST_CALC;
            addr_q  <= '0;
          end else begin
            addr_q  <= addr_q + ADDR_ONE;
          end
        end
        ST_CALC: begin
          for (int i = 0; i < N; i++) x_q[i] <= x_d[i];
          iter_q <= iter_q + ITER_ONE;
          if ((nz_d <= NZ_ONE) || ((iter_q + ITER_ONE) == ITER_LIM)) begin
            state_q <= ST_WRITE;
            addr_q  <= '0;
            we_q    <= 1'b1;
            wdata_q <= x_d[0];
          end
        end
        ST_WRITE: begin
          if (addr_q == ADDR_LAST) begin
            state_q  <= ST_DONE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            done_q   <= 1'b1;
            winner_q <= win_s;
            valid_q  <= (nz_s != '0);
            tie_q    <= (nz_s > NZ_ONE);
          end else begin
            addr_q   <= addr_q + ADDR_ONE;
            wdata_q  <= x_q[addr_q + ADDR_ONE];
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_addr   = addr_q;
  assign mem.mem_we     = we_q;
  assign mem.mem_wdata  = wdata_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign winner_o       = winner_q;
  assign winner_valid_o = valid_q;
  assign tie_o          = tie_q;
  assign iter_count_o   = iter_q;
endmodule

// File: tb/tb_maxnet_controller.sv
// Randomised self-checking bench: a timeline model of each run plus an
// arithmetic MaxNet reference, checked every cycle, with literal anchors.
module tb_maxnet_controller;
  localparam int N = 4, DW = 32, AW = 2, IW = 4, MAXI = 15, EPS = 3;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, winner_valid, tie;
  logic [AW-1:0] winner;
  logic [IW-1:0] iter_count;
  logic [DW-1:0] mem [N];
  int tests = 0, fails = 0;

  maxnet_controller_if #(.AW(AW), .DW(DW)) mif();

  maxnet_controller dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mem(mif),
    .busy_o(busy), .done_o(done), .winner_o(winner), .winner_valid_o(winner_valid),
    .tie_o(tie), .iter_count_o(iter_count)
  );

  always #5 clk = ~clk;

  assign mif.mem_rdata = mem[mif.mem_addr];
  always @(posedge clk) if (mif.mem_we) mem[mif.mem_addr] <= mif.mem_wdata;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain-arithmetic MaxNet iteration on the loaded words.
  function automatic void model(input logic [DW-1:0] m [N], output longint f [N], output int k);
    longint x [N];
    longint nx [N];
    longint s, inh;
    int nz;
    for (int i = 0; i < N; i++) x[i] = m[i][DW-1] ? 0 : longint'(m[i]);
    k = 0;
    do begin
      s = 0;
      for (int i = 0; i < N; i++) s += x[i];
      nz = 0;
      for (int i = 0; i < N; i++) begin
        inh   = (s - x[i]) / (longint'(1) << EPS);
        nx[i] = (x[i] > inh) ? x[i] - inh : 0;
        if (nx[i] != 0) nz++;
      end
      x = nx;
      k++;
    end while (nz > 1 && k < MAXI);
    f = x;
  endfunction

  // Model state for the run timeline.
  bit     active = 0;
  int     rel = 0, k_m = 0, total = 0;
  longint fin_m [N];
  longint hw = 0, hv = 0, ht = 0, hk = 0;
  // Literal anchors for directed cases.
  bit     lit_en = 0;
  int     lit_rel, lit_w, lit_v, lit_t, lit_k;
  longint lit_mem [N];

  // Compare process: every falling edge, DUT outputs against the model timeline.
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 0; hw = 0; hv = 0; ht = 0; hk = 0;
      chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
      chk("rst_we", mif.mem_we, 0);    chk("rst_addr", mif.mem_addr, 0);
      chk("rst_wdata", mif.mem_wdata, 0);
      chk("rst_winner", winner, 0);    chk("rst_valid", winner_valid, 0);
      chk("rst_tie", tie, 0);          chk("rst_iter", iter_count, 0);
    end else begin
      bit ex_done, ex_we;
      longint ex_iter;
      if (active) rel++;
      ex_done = active && (rel == total);
      ex_we   = active && (rel >= N + k_m + 1) && (rel <= 2*N + k_m);
      if (ex_done) begin
        longint best;
        int nz;
        hw = 0; best = fin_m[0]; nz = 0;
        for (int i = 0; i < N; i++) begin
          if (fin_m[i] > best) begin best = fin_m[i]; hw = i; end
          if (fin_m[i] != 0) nz++;
        end
        hv = (nz > 0); ht = (nz > 1); hk = k_m;
      end
      if (!active)        ex_iter = hk;
      else if (rel <= N)  ex_iter = 0;
      else                ex_iter = (rel - N - 1 < k_m) ? rel - N - 1 : k_m;
      chk("busy", busy, active);
      chk("done", done, ex_done);
      chk("mem_we", mif.mem_we, ex_we);
      chk("winner", winner, hw);
      chk("winner_valid", winner_valid, hv);
      chk("tie", tie, ht);
      chk("iter_count", iter_count, ex_iter);
      if (active && rel <= N) chk("load_addr", mif.mem_addr, rel - 1);
      if (ex_we) begin
        int a;
        a = rel - (N + k_m + 1);
        chk("write_addr", mif.mem_addr, a);
        chk("write_data", mif.mem_wdata, fin_m[a]);
      end
      if (ex_done) begin
        for (int i = 0; i < N; i++) chk("mem_final", mem[i], fin_m[i]);
        if (lit_en) begin
          chk("lit_done_cycle", rel, lit_rel);
          chk("lit_winner", winner, lit_w);
          chk("lit_valid", winner_valid, lit_v);
          chk("lit_tie", tie, lit_t);
          chk("lit_iter", iter_count, lit_k);
          for (int i = 0; i < N; i++) chk("lit_mem", mem[i], lit_mem[i]);
          lit_en = 0;
        end
        active = 0;
      end else if (!active && start) begin
        model(mem, fin_m, k_m);
        total  = 2*N + k_m + 1;
        rel    = 0;
        active = 1;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  // Start a run, optionally pulse start again mid-run, and wait for done.
  task automatic run_and_wait(input int pulse_at);
    int  n;
    bit  seen;
    n = 0; seen = 0;
    pulse_start();
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      n++;
      if (n == pulse_at) start = 1'b1;
      if (n == pulse_at + 1) start = 1'b0;
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic directed(input logic [DW-1:0] v0, v1, v2, v3,
                          input int erel, ew, ev, et, ek,
                          input longint m0, m1, m2, m3, input int pulse_at);
    mem[0] = v0; mem[1] = v1; mem[2] = v2; mem[3] = v3;
    lit_rel = erel; lit_w = ew; lit_v = ev; lit_t = et; lit_k = ek;
    lit_mem[0] = m0; lit_mem[1] = m1; lit_mem[2] = m2; lit_mem[3] = m3;
    lit_en = 1;
    run_and_wait(pulse_at);
    chk("lit_consumed", lit_en, 0);
  endtask

  initial begin
    int  sel;
    bit  seen;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    directed(32'd10, 32'd20, 32'd30, 32'd40, 17, 3, 1, 0, 8, 0, 0, 0, 25, 0);
    directed(32'd0, 32'd0, 32'd5, 32'd0,     10, 2, 1, 0, 1, 0, 0, 5, 0, 0);
    directed(32'd7, 32'd7, 32'd0, 32'd0,     24, 0, 1, 1, 15, 7, 7, 0, 0, 0);
    directed(32'd0, 32'd0, 32'd0, 32'd0,     10, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    directed(-32'sd5, 32'd0, 32'd0, 32'd0,   10, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Extra start during CALC must be ignored.
    directed(32'd10, 32'd20, 32'd30, 32'd40, 17, 3, 1, 0, 8, 0, 0, 0, 25, 7);

    // Reset during write-back: mem_we must drop without waiting for a clock.
    mem[0] = 32'd100; mem[1] = 32'd90; mem[2] = 32'd80; mem[3] = 32'd70;
    pulse_start();
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (mif.mem_we) seen = 1;
    end
    chk("reached_write", seen, 1);
    #1 rst_n = 1'b0;
    #1 chk("async_we_drop", mif.mem_we, 0);
    chk("async_busy_drop", busy, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    directed(32'd10, 32'd20, 32'd30, 32'd40, 17, 3, 1, 0, 8, 0, 0, 0, 25, 0);

    // Randomised runs: small values, full-range words (incl. negatives), ties, zeros.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        sel = $urandom_range(0, 3);
        case (sel)
          0:       mem[i] = DW'($urandom_range(0, 50));
          1:       mem[i] = $urandom;
          2:       mem[i] = (i > 0) ? mem[i-1] : DW'($urandom_range(1, 9));
          default: mem[i] = '0;
        endcase
      end
      run_and_wait(0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
